// File: rtl/bus_arbiter_param_pkg.sv
// bus_arbiter_param_pkg: FSM states, policy codes and counter sizing shared by the arbiter files.
package bus_arbiter_param_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, GRANT = 2'd1, TURN = 2'd2} arb_state_e;
   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction
endpackage

// File: rtl/bus_arbiter_param_picker.sv
// bus_arbiter_param_picker: combinational winner select, fixed priority or round-robin after last.
module bus_arbiter_param_picker #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req_i,
   input  logic [W-1:0] last_i,
   input  logic         rr_mode_i,
   output logic         valid_o,
   output logic [W-1:0] winner_o,
   output logic [N-1:0] onehot_o
);
   logic [W-1:0] idx;
   logic         found;
   always_comb begin
      valid_o  = |req_i;
      winner_o = '0;
      found    = 1'b0;
      idx      = '0;
      for (int k = 0; k < N; k++) begin
         idx = rr_mode_i ? W'((int'(last_i) + k + 1) % N) : W'(k);
         if (!found && req_i[idx]) begin
            winner_o = idx;
            found    = 1'b1;
         end
      end
      onehot_o = valid_o ? (N'(1) << winner_o) : '0;
   end
endmodule

// File: rtl/bus_arbiter_param.sv
// bus_arbiter_param: N-master bus arbiter with IDLE/GRANT/TURN tenure FSM and optional hold timeout.
module bus_arbiter_param import bus_arbiter_param_pkg::*; #(
   parameter  int N_MASTERS = 4,
   parameter  int RR_MODE   = 1,
   parameter  int MAX_HOLD  = 16,
   localparam int OWNER_W   = $clog2(N_MASTERS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_MASTERS-1:0] req,
   output logic [N_MASTERS-1:0] gnt,
   output logic [OWNER_W-1:0]   owner,
   output logic                 bus_busy,
   output logic                 timeout
);
   localparam int HOLD_W = cnt_w(MAX_HOLD);
   arb_state_e             state_q;
   logic [N_MASTERS-1:0]   gnt_q;
   logic [OWNER_W-1:0]     owner_q, last_q, pick_w;
   logic [HOLD_W-1:0]      hold_q;
   logic                   busy_q, timeout_q, pick_valid;
   logic [N_MASTERS-1:0]   pick_oh;
   bus_arbiter_param_picker #(.N(N_MASTERS), .W(OWNER_W)) u_picker (
      .req_i     (req),
      .last_i    (last_q),
      .rr_mode_i (RR_MODE == ARB_RR),
      .valid_o   (pick_valid),
      .winner_o  (pick_w),
      .onehot_o  (pick_oh)
   );
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         owner_q   <= '0;
         last_q    <= OWNER_W'(N_MASTERS - 1);
         hold_q    <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: if (pick_valid) begin
               gnt_q   <= pick_oh;
               owner_q <= pick_w;
               last_q  <= pick_w;
               hold_q  <= HOLD_W'(1);
               busy_q  <= 1'b1;
               state_q <= GRANT;
            end
            GRANT: if (!req[owner_q]) begin
               gnt_q   <= '0;
               busy_q  <= 1'b0;
               state_q <= TURN;
            end else if (MAX_HOLD != 0 && hold_q == HOLD_W'(MAX_HOLD)) begin
               gnt_q     <= '0;
               busy_q    <= 1'b0;
               timeout_q <= 1'b1;
               state_q   <= TURN;
            end else if (hold_q != '1) begin
               hold_q <= hold_q + 1'b1;
            end
            // dead cycle keeps adjacent tenures from overlapping on the bus
            TURN:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign gnt      = gnt_q;
   assign owner    = owner_q;
   assign bus_busy = busy_q;
   assign timeout  = timeout_q;
endmodule

// File: tb/tb_bus_arbiter_param.sv
// tb_bus_arbiter_param: directed scenarios plus randomized run against a tenure-level reference model.
module tb_bus_arbiter_param;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [3:0] req = 4'b0000;
   logic [2:0][3:0] gnt_v;
   logic [2:0][1:0] own_v;
   logic [2:0] busy_v, to_v;
   int n_cmp = 0;
   int n_fail = 0;
   int rr_p[3] = '{1, 1, 0};
   int mh_p[3] = '{4, 0, 4};

   always #5 clk = ~clk;

   bus_arbiter_param #(.N_MASTERS(4), .RR_MODE(1), .MAX_HOLD(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_v[0]), .owner(own_v[0]), .bus_busy(busy_v[0]), .timeout(to_v[0]));
   bus_arbiter_param #(.N_MASTERS(4), .RR_MODE(1), .MAX_HOLD(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_v[1]), .owner(own_v[1]), .bus_busy(busy_v[1]), .timeout(to_v[1]));
   bus_arbiter_param #(.N_MASTERS(4), .RR_MODE(0), .MAX_HOLD(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt_v[2]), .owner(own_v[2]), .bus_busy(busy_v[2]), .timeout(to_v[2]));

   typedef struct {
      int ph;
      int own;
      int last;
      int held;
      bit to;
   } mdl_t;
   mdl_t m[3];

   function automatic int pick(logic [3:0] r, int last, bit rr);
      for (int k = 0; k < 4; k++) begin
         int c;
         c = rr ? (last + 1 + k) % 4 : k;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   // ph: 0 = bus free, 1 = owned, 2 = mandatory dead cycle
   function automatic mdl_t mstep(mdl_t s, logic [3:0] r, bit rst, bit rr, int maxh);
      mdl_t n;
      int w;
      n = s;
      n.to = 1'b0;
      if (rst) begin
         n.ph = 0; n.own = 0; n.last = 3; n.held = 0;
         return n;
      end
      if (s.ph == 0) begin
         w = pick(r, s.last, rr);
         if (w >= 0) begin
            n.ph = 1; n.own = w; n.last = w; n.held = 1;
         end
      end else if (s.ph == 1) begin
         if (!r[s.own]) n.ph = 2;
         else if (maxh != 0 && s.held == maxh) begin
            n.ph = 2; n.to = 1'b1;
         end else n.held = s.held + 1;
      end else n.ph = 0;
      return n;
   endfunction

   function automatic logic [3:0] exp_gnt(mdl_t s);
      return (s.ph == 1) ? (4'b0001 << s.own) : 4'b0000;
   endfunction

   task automatic apply_reset(input logic [3:0] r);
      @(negedge clk);
      rst_n = 1'b0;
      req = r;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst_n = 1'b0;
      req = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (gnt_v[0] !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt cyc=%0d got=%b want=0000", i, gnt_v[0]); end
         n_cmp++;
         if (own_v[0] !== 2'd0) begin n_fail++; $display("FAIL reset_owner cyc=%0d got=%0d want=0", i, own_v[0]); end
         n_cmp++;
         if (busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL reset_busy cyc=%0d got=%b want=0", i, busy_v[0]); end
         n_cmp++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      if (gnt_v[0] !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt got=%b want=0001", gnt_v[0]); end
      n_cmp++;
      if (busy_v[0] !== 1'b1) begin n_fail++; $display("FAIL reset_first_busy got=%b want=1", busy_v[0]); end
      n_cmp++;
      if (gnt_v[2] !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt_fixed got=%b want=0001", gnt_v[2]); end
      n_cmp++;
   endtask

   task automatic test_rr_fairness;
      int ord[5] = '{0, 1, 2, 3, 0};
      apply_reset(4'b1111);
      for (int i = 0; i < 5; i++) begin
         logic [3:0] want;
         want = 4'b0001 << ord[i];
         @(posedge clk); #1;
         if (gnt_v[1] !== want) begin n_fail++; $display("FAIL rr_order idx=%0d got=%b want=%b", i, gnt_v[1], want); end
         n_cmp++;
         if (own_v[1] !== 2'(ord[i])) begin n_fail++; $display("FAIL rr_owner idx=%0d got=%0d want=%0d", i, own_v[1], ord[i]); end
         n_cmp++;
         @(posedge clk); #1;
         if (gnt_v[1] !== want) begin n_fail++; $display("FAIL rr_hold idx=%0d got=%b want=%b", i, gnt_v[1], want); end
         n_cmp++;
         @(negedge clk);
         req[ord[i]] = 1'b0;
         @(posedge clk); #1;
         if (gnt_v[1] !== 4'b0000) begin n_fail++; $display("FAIL rr_turn idx=%0d got=%b want=0000", i, gnt_v[1]); end
         n_cmp++;
         @(negedge clk);
         req[ord[i]] = 1'b1;
         @(posedge clk); #1;
         if (gnt_v[1] !== 4'b0000) begin n_fail++; $display("FAIL rr_idle idx=%0d got=%b want=0000", i, gnt_v[1]); end
         n_cmp++;
      end
      if (to_v[1] !== 1'b0) begin n_fail++; $display("FAIL rr_no_timeout got=%b want=0", to_v[1]); end
      n_cmp++;
   endtask

   task automatic test_fixed;
      apply_reset(4'b1010);
      @(posedge clk); #1;
      if (gnt_v[2] !== 4'b0010) begin n_fail++; $display("FAIL fixed_gnt1 got=%b want=0010", gnt_v[2]); end
      n_cmp++;
      if (own_v[2] !== 2'd1) begin n_fail++; $display("FAIL fixed_owner got=%0d want=1", own_v[2]); end
      n_cmp++;
      @(negedge clk);
      req = 4'b0000;
      @(posedge clk); #1;
      if (gnt_v[2] !== 4'b0000) begin n_fail++; $display("FAIL fixed_release got=%b want=0000", gnt_v[2]); end
      n_cmp++;
      @(negedge clk);
      req = 4'b1010;
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (gnt_v[2] !== 4'b0010) begin n_fail++; $display("FAIL fixed_gnt2 got=%b want=0010", gnt_v[2]); end
      n_cmp++;
      if (gnt_v[0] !== 4'b1000) begin n_fail++; $display("FAIL rr_contrast_gnt got=%b want=1000", gnt_v[0]); end
      n_cmp++;
   endtask

   task automatic test_timeout;
      apply_reset(4'b0100);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (gnt_v[0] !== 4'b0100) begin n_fail++; $display("FAIL to_hold cyc=%0d got=%b want=0100", i, gnt_v[0]); end
         n_cmp++;
         if (to_v[0] !== 1'b0) begin n_fail++; $display("FAIL to_early cyc=%0d got=%b want=0", i, to_v[0]); end
         n_cmp++;
      end
      @(posedge clk); #1;
      if (gnt_v[0] !== 4'b0000) begin n_fail++; $display("FAIL to_revoke_gnt got=%b want=0000", gnt_v[0]); end
      n_cmp++;
      if (to_v[0] !== 1'b1) begin n_fail++; $display("FAIL to_pulse got=%b want=1", to_v[0]); end
      n_cmp++;
      if (to_v[2] !== 1'b1) begin n_fail++; $display("FAIL to_pulse_fixed got=%b want=1", to_v[2]); end
      n_cmp++;
      @(posedge clk); #1;
      if (to_v[0] !== 1'b0) begin n_fail++; $display("FAIL to_pulse_width got=%b want=0", to_v[0]); end
      n_cmp++;
      if (gnt_v[0] !== 4'b0000) begin n_fail++; $display("FAIL to_turn_gnt got=%b want=0000", gnt_v[0]); end
      n_cmp++;
      @(posedge clk); #1;
      if (gnt_v[0] !== 4'b0100) begin n_fail++; $display("FAIL to_regrant got=%b want=0100", gnt_v[0]); end
      n_cmp++;
   endtask

   task automatic test_mid_reset;
      apply_reset(4'b1000);
      @(posedge clk); #1;
      if (own_v[0] !== 2'd3) begin n_fail++; $display("FAIL mid_owner3 got=%0d want=3", own_v[0]); end
      n_cmp++;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      if (gnt_v[0] !== 4'b0000) begin n_fail++; $display("FAIL mid_gnt got=%b want=0000", gnt_v[0]); end
      n_cmp++;
      if (own_v[0] !== 2'd0) begin n_fail++; $display("FAIL mid_owner got=%0d want=0", own_v[0]); end
      n_cmp++;
      if (to_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin n_fail++; $display("FAIL mid_to_busy got=%b%b want=00", to_v[0], busy_v[0]); end
      n_cmp++;
      @(negedge clk);
      rst_n = 1'b1;
      req = 4'b1111;
      @(posedge clk); #1;
      if (gnt_v[0] !== 4'b0001) begin n_fail++; $display("FAIL mid_restart got=%b want=0001", gnt_v[0]); end
      n_cmp++;
   endtask

   task automatic test_wrap;
      apply_reset(4'b1000);
      @(posedge clk); #1;
      @(negedge clk);
      req = 4'b0001;
      @(posedge clk);
      @(negedge clk);
      req = 4'b1001;
      @(posedge clk);
      @(posedge clk); #1;
      if (gnt_v[0] !== 4'b0001) begin n_fail++; $display("FAIL wrap_first got=%b want=0001", gnt_v[0]); end
      n_cmp++;
      @(negedge clk);
      req = 4'b1000;
      @(posedge clk);
      @(negedge clk);
      req = 4'b1001;
      @(posedge clk);
      @(posedge clk); #1;
      if (gnt_v[0] !== 4'b1000) begin n_fail++; $display("FAIL wrap_second got=%b want=1000", gnt_v[0]); end
      n_cmp++;
   endtask

   task automatic test_random;
      for (int d = 0; d < 3; d++) m[d] = '{ph: 0, own: 0, last: 3, held: 0, to: 1'b0};
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
         for (int d = 0; d < 3; d++) m[d] = mstep(m[d], req, !rst_n, rr_p[d] != 0, mh_p[d]);
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) begin
            if (gnt_v[d] !== exp_gnt(m[d])) begin n_fail++; $display("FAIL rnd_gnt dut=%0d cyc=%0d got=%b want=%b", d, i, gnt_v[d], exp_gnt(m[d])); end
            n_cmp++;
            if (own_v[d] !== 2'(m[d].own)) begin n_fail++; $display("FAIL rnd_owner dut=%0d cyc=%0d got=%0d want=%0d", d, i, own_v[d], m[d].own); end
            n_cmp++;
            if (busy_v[d] !== (m[d].ph == 1)) begin n_fail++; $display("FAIL rnd_busy dut=%0d cyc=%0d got=%b want=%b", d, i, busy_v[d], m[d].ph == 1); end
            n_cmp++;
            if (to_v[d] !== m[d].to) begin n_fail++; $display("FAIL rnd_timeout dut=%0d cyc=%0d got=%b want=%b", d, i, to_v[d], m[d].to); end
            n_cmp++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_rr_fairness();
      test_fixed();
      test_timeout();
      test_mid_reset();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
